// File: rtl/disp_pkg.sv
// Shared definitions for the display scheduler and the xdisp 7-segment driver.
package disp_pkg;

    localparam int DISP_W = 11;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Digit codes understood by xdisp for non-numeric glyphs.
    localparam logic [3:0] BLANK_CODE = 4'b1011;
    localparam logic [3:0] MINUS_CODE = 4'b1010;

    // Next index with wrap-around, used for auto-rotation.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/disp_sched_rr_arb.sv
// Combinational round-robin pick: first set request bit after ptr, with wrap-around.
module rr_arb #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] grant,
    output logic          any
);

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        grant = '0;
        // Walk from the farthest offset to the nearest so the closest request wins.
        for (int off = N; off >= 1; off--) begin
            int idx;
            idx = (int'(ptr) + off) % N;
            if (req[idx]) begin
                grant = IW'(idx);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/disp_sched.sv
// Time-shares the xdisp 7-segment driver among N_SRC sources, by request or rotation.
module disp_sched
    import disp_pkg::*;
#(
    parameter int N_SRC    = 4,
    parameter int DW       = DISP_W,
    parameter int HOLD_CYC = 50_000_000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_SRC-1:0]           req,
    input  logic [N_SRC*DW-1:0]        src_data,
    input  logic                       rotate_en,
    output logic [N_SRC-1:0]           ack,
    output logic [DW-1:0]              disp_data,
    output logic                       disp_sel,
    output logic [$clog2(N_SRC)-1:0]   cur_src,
    output logic                       busy
);

    localparam int SW    = $clog2(N_SRC);
    localparam int CNT_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [SW-1:0]      ptr;
    logic [SW-1:0]      arb_grant;
    logic               arb_any;
    logic               load;
    logic               load_ack;
    logic [SW-1:0]      load_idx;

    rr_arb #(
        .N  (N_SRC),
        .IW (SW)
    ) u_rr_arb (
        .req   (req),
        .ptr   (ptr),
        .grant (arb_grant),
        .any   (arb_any)
    );

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        load_ack  = 1'b0;
        load_idx  = cur_src;
        case (state)
            IDLE: begin
                // A pending request always beats auto-rotation.
                if (arb_any) begin
                    load      = 1'b1;
                    load_ack  = 1'b1;
                    load_idx  = arb_grant;
                    state_nxt = HOLD;
                end else if (rotate_en) begin
                    load      = 1'b1;
                    load_idx  = SW'(wrap_inc(int'(cur_src), N_SRC));
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            disp_data <= '0;
            disp_sel  <= 1'b0;
            ack       <= '0;
            cur_src   <= '0;
            busy      <= 1'b0;
            cnt       <= '0;
            ptr       <= SW'(N_SRC - 1);
        end else begin
            state <= state_nxt;
            ack   <= '0;
            if (load) begin
                disp_data <= src_data[int'(load_idx)*DW +: DW];
                disp_sel  <= ~disp_sel;
                cur_src   <= load_idx;
                cnt       <= CNT_W'(HOLD_CYC - 1);
                busy      <= 1'b1;
                if (load_ack) begin
                    ack[load_idx] <= 1'b1;
                    ptr           <= load_idx;
                end
            end else if (state == HOLD) begin
                if (cnt == '0) begin
                    busy <= 1'b0;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_disp_sched.sv
// Directed self-checking bench for disp_sched with N_SRC=4, HOLD_CYC=4.
module tb_disp_sched;

    localparam int N_SRC    = 4;
    localparam int DW       = 11;
    localparam int HOLD_CYC = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N_SRC-1:0]     req;
    logic [DW-1:0]        srcv [N_SRC];
    logic [N_SRC*DW-1:0]  src_data;
    logic                 rotate_en;
    logic [N_SRC-1:0]     ack;
    logic [DW-1:0]        disp_data;
    logic                 disp_sel;
    logic [1:0]           cur_src;
    logic                 busy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    logic exp_sel;

    assign src_data = {srcv[3], srcv[2], srcv[1], srcv[0]};

    always #5 clk = ~clk;

    disp_sched #(
        .N_SRC    (N_SRC),
        .DW       (DW),
        .HOLD_CYC (HOLD_CYC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .src_data  (src_data),
        .rotate_en (rotate_en),
        .ack       (ack),
        .disp_data (disp_data),
        .disp_sel  (disp_sel),
        .cur_src   (cur_src),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst     = 1'b0;
        exp_sel = 1'b0;
    endtask

    task automatic wait_ack(output logic [N_SRC-1:0] a);
        a = '0;
        for (int i = 0; i < 12 && a == '0; i++) begin
            tick();
            a = ack;
        end
        if (a == '0) check("ack_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic [N_SRC-1:0] a;
        int               order [3];
        int               t_last;
        int               exp_idx;

        rst       = 1'b1;
        req       = '0;
        rotate_en = 1'b0;
        exp_sel   = 1'b0;
        srcv[0]   = 11'h100;
        srcv[1]   = 11'h201;
        srcv[2]   = 11'd123;
        srcv[3]   = 11'h3FF;

        // 1. Reset state held while idle with nothing to show.
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("rst_sel",  32'(disp_sel),  32'd0);
            check("rst_data", 32'(disp_data), 32'd0);
            check("rst_ack",  32'(ack),       32'd0);
            check("rst_busy", 32'(busy),      32'd0);
        end
        check("rst_cur", 32'(cur_src), 32'd0);

        // 2. Single request from source 2.
        req = 4'b0100;
        tick();
        check("t2_ack",  32'(ack),       32'b0100);
        check("t2_data", 32'(disp_data), 32'd123);
        check("t2_sel",  32'(disp_sel),  32'd1);
        check("t2_busy", 32'(busy),      32'd1);
        check("t2_cur",  32'(cur_src),   32'd2);
        req = '0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("t2_busy_hold", 32'(busy),      32'd1);
            check("t2_ack_pulse", 32'(ack),       32'd0);
            check("t2_data_hold", 32'(disp_data), 32'd123);
            check("t2_sel_hold",  32'(disp_sel),  32'd1);
        end
        tick();
        check("t2_busy_end", 32'(busy), 32'd0);

        // 3. Three concurrent requests served round-robin from a fresh pointer.
        do_reset();
        order[0] = 0;
        order[1] = 1;
        order[2] = 3;
        req    = 4'b1011;
        t_last = cyc;
        for (int k = 0; k < 3; k++) begin
            wait_ack(a);
            exp_sel = ~exp_sel;
            check("t3_ack",  32'(a),         32'(1) << order[k]);
            check("t3_data", 32'(disp_data), 32'(srcv[order[k]]));
            check("t3_cur",  32'(cur_src),   32'(order[k]));
            check("t3_sel",  32'(disp_sel),  32'(exp_sel));
            check("t3_gap",  32'(cyc - t_last), (k == 0) ? 32'd1 : 32'd5);
            t_last = cyc;
            req[order[k]] = 1'b0;
        end

        // 4. Auto-rotation from reset: 1,2,3,0 every 5 cycles, never acked.
        do_reset();
        rotate_en = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            tick();
            check("t4_ack", 32'(ack), 32'd0);
            if ((i - 1) % 5 == 0) begin
                exp_idx = ((i - 1) / 5 + 1) % 4;
                exp_sel = ~exp_sel;
                check("t4_cur",  32'(cur_src),   32'(exp_idx));
                check("t4_data", 32'(disp_data), 32'(srcv[exp_idx]));
                check("t4_sel",  32'(disp_sel),  32'(exp_sel));
            end
        end

        // 5. Request for source 3 raised mid-HOLD beats the next rotation step (1).
        req = 4'b1000;
        for (int i = 18; i <= 20; i++) begin
            tick();
            check("t5_ack_wait", 32'(ack), 32'd0);
        end
        tick();
        check("t5_ack",  32'(ack),       32'b1000);
        check("t5_cur",  32'(cur_src),   32'd3);
        check("t5_data", 32'(disp_data), 32'(srcv[3]));
        req       = '0;
        rotate_en = 1'b0;
        repeat (4) tick();
        check("t5_idle", 32'(busy), 32'd0);

        // 6. Reset during HOLD aborts the dwell; next request starts from source 0.
        srcv[1] = 11'h7F6;
        req     = 4'b0010;
        tick();
        check("t6_ack",  32'(ack),       32'b0010);
        check("t6_data", 32'(disp_data), 32'h7F6);
        req = '0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_rst_sel",  32'(disp_sel),  32'd0);
        check("t6_rst_data", 32'(disp_data), 32'd0);
        check("t6_rst_ack",  32'(ack),       32'd0);
        check("t6_rst_busy", 32'(busy),      32'd0);
        check("t6_rst_cur",  32'(cur_src),   32'd0);
        req = 4'b0011;
        tick();
        check("t6_ack0",  32'(ack),       32'b0001);
        check("t6_cur0",  32'(cur_src),   32'd0);
        check("t6_data0", 32'(disp_data), 32'(srcv[0]));
        check("t6_sel0",  32'(disp_sel),  32'd1);
        req = '0;
        tick();
        check("t6_ack_once", 32'(ack), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
